// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input row of a combinational block, samples its outputs after
// a settle delay and compares the captured truth table against an expected one.
module truth_table_sweeper #(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 2,
   parameter int SETTLE = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic [N_OUT*2**N_IN-1:0]  expected_tt,
   output logic [N_IN-1:0]           drive_in,
   input  logic [N_OUT-1:0]          sample_out,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [N_OUT*2**N_IN-1:0]  result_tt,
   output logic [N_IN:0]             fail_count,
   output logic [N_IN-1:0]           first_fail_idx
);
   localparam int ROWS = 2**N_IN;
   localparam int TW   = N_OUT*ROWS;
   localparam int CW   = SETTLE > 1 ? $clog2(SETTLE) : 1;
   localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS-1);
   localparam logic [CW-1:0]   LAST_CNT = CW'(SETTLE-1);
   localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_SAMPLE = 2'd2, S_DONE = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d, ffi_q, ffi_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   exp_q, exp_d, res_q, res_d;
   logic [N_IN:0]   fail_q, fail_d;
   logic            pass_q, pass_d;
   logic            mism;

   assign busy           = state_q == S_WAIT || state_q == S_SAMPLE;
   assign done           = state_q == S_DONE;
   assign drive_in       = busy ? idx_q : '0;
   assign pass           = pass_q;
   assign result_tt      = res_q;
   assign fail_count     = fail_q;
   assign first_fail_idx = ffi_q;
   assign mism           = sample_out != exp_q[idx_q*N_OUT +: N_OUT];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      res_d   = res_q;
      fail_d  = fail_q;
      ffi_d   = ffi_q;
      pass_d  = pass_q;
      if (state_q == S_IDLE && start) begin
         state_d = S_WAIT;
         exp_d   = expected_tt;
         res_d   = '0;
         fail_d  = '0;
         ffi_d   = '0;
         pass_d  = 1'b0;
         idx_d   = '0;
         cnt_d   = '0;
      end else if (busy && abort) begin
         state_d = S_IDLE;
      end else if (state_q == S_WAIT) begin
         cnt_d   = cnt_q + 1'b1;
         state_d = cnt_q == LAST_CNT ? S_SAMPLE : S_WAIT;
      end else if (state_q == S_SAMPLE) begin
         res_d[idx_q*N_OUT +: N_OUT] = sample_out;
         fail_d = mism ? fail_q + 1'b1 : fail_q;
         ffi_d  = mism && fail_q == '0 ? idx_q : ffi_q;
         if (idx_q == LAST_ROW) begin
            state_d = S_DONE;
            pass_d  = fail_d == '0;
         end else begin
            state_d = S_WAIT;
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
         end
      end else if (state_q == S_DONE) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         res_q   <= '0;
         fail_q  <= '0;
         ffi_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         res_q   <= res_d;
         fail_q  <= fail_d;
         ffi_q   <= ffi_d;
         pass_q  <= pass_d;
      end
   end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed and random sweeps checked against a row/cycle arithmetic model.
module tb_truth_table_sweeper;
   localparam int N_IN = 3, N_OUT = 2, SETTLE = 2;
   localparam int ROWS = 1 << N_IN, TW = N_OUT*ROWS, HOLD = SETTLE+1;

   logic clk = 0, rst = 1, start = 0, abort = 0;
   logic [TW-1:0] expected_tt = '0;
   logic [N_IN-1:0] drive_in;
   logic [N_OUT-1:0] sample_out, dly_q = '0;
   logic busy, done, pass;
   logic [TW-1:0] result_tt;
   logic [N_IN:0] fail_count;
   logic [N_IN-1:0] first_fail_idx;
   logic [TW-1:0] blk_tt = 16'h23B3;
   logic dly_mode = 0;
   int tests = 0, fails = 0;

   truth_table_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .expected_tt(expected_tt),
      .drive_in(drive_in), .sample_out(sample_out), .busy(busy), .done(done), .pass(pass),
      .result_tt(result_tt), .fail_count(fail_count), .first_fail_idx(first_fail_idx));

   always #5 clk = ~clk;

   always @(posedge clk) dly_q <= blk_tt[drive_in*N_OUT +: N_OUT];
   assign sample_out = dly_mode ? dly_q : blk_tt[drive_in*N_OUT +: N_OUT];

   function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endfunction

   // Model: k edges since start; row = k/HOLD, row r is sampled on edge k=(r+1)*HOLD.
   logic m_run = 0, m_done = 0, m_pass = 0;
   int m_k = 0, m_r = 0, m_fail = 0, m_ffi = 0;
   logic [TW-1:0] m_exp = '0, m_tt = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_run = 0; m_done = 0; m_pass = 0; m_k = 0; m_fail = 0; m_ffi = 0; m_exp = '0; m_tt = '0;
      end else if (m_done) m_done = 0;
      else if (!m_run) begin
         if (start) begin
            m_run = 1; m_k = 0; m_exp = expected_tt; m_tt = '0; m_fail = 0; m_ffi = 0; m_pass = 0;
         end
      end else if (abort) m_run = 0;
      else begin
         m_k++;
         if (m_k % HOLD == 0) begin
            m_r = m_k/HOLD - 1;
            m_tt[m_r*N_OUT +: N_OUT] = sample_out;
            if (sample_out !== m_exp[m_r*N_OUT +: N_OUT]) begin
               if (m_fail == 0) m_ffi = m_r;
               m_fail++;
            end
            if (m_r == ROWS-1) begin
               m_run = 0; m_done = 1; m_pass = m_fail == 0;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (!rst) begin
         chk("busy", busy, m_run);
         chk("done", done, m_done);
         chk("pass", pass, m_pass);
         chk("drive_in", drive_in, m_run ? m_k/HOLD : 0);
         chk("result_tt", result_tt, m_tt);
         chk("fail_count", fail_count, m_fail);
         chk("first_fail_idx", first_fail_idx, m_ffi);
      end
   end

   task automatic run_sweep(input logic [TW-1:0] e, input int glitch, output int lat);
      expected_tt = e;
      start = 1;
      @(negedge clk);
      start = 0;
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
         start = lat == glitch;
      end
      start = 0;
      chk("sweep_timeout", lat < 100, 1);
   endtask

   task automatic chk_zero(string n);
      chk({n, "_busy"}, busy, 0);
      chk({n, "_done"}, done, 0);
      chk({n, "_pass"}, pass, 0);
      chk({n, "_drive"}, drive_in, 0);
      chk({n, "_result"}, result_tt, 0);
      chk({n, "_fcnt"}, fail_count, 0);
      chk({n, "_ffi"}, first_fail_idx, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, c;
      int hold [ROWS];
      logic seen;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 0;
      @(negedge clk);
      // Matching sweep
      run_sweep(16'h23B3, -1, lat);
      chk("t1_latency", lat, 24);
      chk("t1_result", result_tt, 16'h23B3);
      chk("t1_pass", pass, 1);
      chk("t1_fcnt", fail_count, 0);
      chk("t1_model_tt", m_tt, 16'h23B3);
      @(negedge clk);
      chk("t1_done_pulse", done, 0);
      chk("t1_hold_result", result_tt, 16'h23B3);
      // Mismatch only in row 0
      run_sweep(16'h23B0, -1, lat);
      chk("t2_fcnt", fail_count, 1);
      chk("t2_ffi", first_fail_idx, 0);
      chk("t2_pass", pass, 0);
      chk("t2_model_fail", m_fail, 1);
      @(negedge clk);
      // Delayed block, drive hold lengths
      dly_mode = 1;
      foreach (hold[i]) hold[i] = 0;
      expected_tt = 16'h23B3;
      start = 1;
      @(negedge clk);
      start = 0;
      c = 0;
      while (!done && c < 100) begin
         if (busy) hold[drive_in]++;
         @(negedge clk);
         c++;
      end
      chk("t3_latency", c, 24);
      for (int i = 0; i < ROWS; i++) chk("t3_hold", hold[i], HOLD);
      chk("t3_result", result_tt, 16'h23B3);
      chk("t3_pass", pass, 1);
      dly_mode = 0;
      @(negedge clk);
      // Abort at row 4
      expected_tt = 16'h23B3;
      start = 1;
      @(negedge clk);
      start = 0;
      c = 0;
      while (drive_in != 4 && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("t4_reach_row4", drive_in, 4);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("t4_busy", busy, 0);
      chk("t4_done", done, 0);
      chk("t4_drive", drive_in, 0);
      chk("t4_result", result_tt, 16'h00B3);
      chk("t4_pass", pass, 0);
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         seen |= done;
      end
      chk("t4_no_done", seen, 0);
      run_sweep(16'h23B3, -1, lat);
      chk("t4_restart_latency", lat, 24);
      chk("t4_restart_pass", pass, 1);
      @(negedge clk);
      // start while busy is ignored
      run_sweep(16'h0000, 5, lat);
      chk("t5_latency", lat, 24);
      chk("t5_fcnt", fail_count, 5);
      chk("t5_ffi", first_fail_idx, 0);
      @(negedge clk);
      // Asynchronous reset mid-WAIT
      expected_tt = 16'h23B3;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      chk("t5_pre_rst_busy", busy, 1);
      chk("t5_pre_rst_drive", drive_in, 1);
      #2 rst = 1;
      #1 chk_zero("async_rst");
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      // Random stimulus
      for (int i = 0; i < 800; i++) begin
         start = $urandom_range(0, 7) == 0;
         abort = $urandom_range(0, 39) == 0;
         if (!busy) begin
            blk_tt = TW'($urandom);
            expected_tt = $urandom_range(0, 1) ? blk_tt : TW'($urandom);
            dly_mode = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      start = 0;
      abort = 0;
      repeat (30) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
